// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle between the writeback requesters and the register-file
// write port arbiter.
//   slave  : the arbiter side (consumes requests, drives grants and the write port)
//   master : the requester / register-file side
interface wb_port_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
);
    logic                 wb_hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic                 RegWrite;
    logic [AW-1:0]        WriteReg;
    logic [DW-1:0]        WriteData;
    logic [1:0]           grant_id;

    modport slave (
        input  wb_hold,
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output RegWrite,
        output WriteReg,
        output WriteData,
        output grant_id
    );

    modport master (
        output wb_hold,
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  RegWrite,
        input  WriteReg,
        input  WriteData,
        input  grant_id
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// NREQ (2..4) writeback requesters. The accepted request is captured into a
// registered stage that drives RegWrite/WriteReg/WriteData for one cycle.
// Optional feature macro: WB_R0_DISCARD_EN -- requests to register 0 are still
// accepted and advance the pointer, but produce no register-file write.
module wb_port_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input logic              clk,
    input logic              rst,    // asynchronous, active-low
    wb_port_arbiter_if.slave wb
);

    // Round-robin pointer: the requester with the highest priority next cycle.
    logic [1:0]      ptr_q;
    logic [1:0]      ptr_d;

    // Arbitration results for the current cycle.
    logic            found_c;
    logic [1:0]      pick_c;
    logic            xfer_c;
    logic [NREQ-1:0] ready_c;
    logic [AW-1:0]   win_addr_c;
    logic [DW-1:0]   win_data_c;

    // Registered write-port stage.
    logic            reg_write_q;
    logic            reg_write_d;
    logic [AW-1:0]   write_reg_q;
    logic [AW-1:0]   write_reg_d;
    logic [DW-1:0]   write_data_q;
    logic [DW-1:0]   write_data_d;
    logic [1:0]      grant_id_q;
    logic [1:0]      grant_id_d;

    // Find the first valid requester scanning upward from ptr with wrap; offsets
    // are walked high-to-low so the nearest valid requester is the last write.
    always_comb begin
        int idx;
        idx     = 0;
        found_c = 1'b0;
        pick_c  = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (wb.req_valid[idx]) begin
                found_c = 1'b1;
                pick_c  = 2'(idx);
            end
        end
    end

    // No grant while held or while reset is asserted.
    assign xfer_c = found_c & ~wb.wb_hold & rst;

    // One-hot ready towards the winning requester only.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign ready_c[gi] = xfer_c && (pick_c == 2'(gi));
        end
    endgenerate

    assign wb.req_ready = ready_c;

    // Select the winner's address and data slices.
    always_comb begin
        win_addr_c = '0;
        win_data_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_c == 2'(i)) begin
                win_addr_c = wb.req_addr[i*AW +: AW];
                win_data_c = wb.req_data[i*DW +: DW];
            end
        end
    end

    // Pointer moves just past the accepted requester; otherwise it holds.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer_c) begin
            ptr_d = 2'((int'(pick_c) + 1) % NREQ);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Output stage next state: pulse RegWrite on a transfer, otherwise keep the
    // last address/data/id so the register file sees stable inputs.
    always_comb begin
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        grant_id_d   = grant_id_q;
        if (xfer_c) begin
`ifdef WB_R0_DISCARD_EN
            // Register 0 is hard-wired; the request is consumed without a write.
            if (win_addr_c != '0) begin
                reg_write_d  = 1'b1;
                write_reg_d  = win_addr_c;
                write_data_d = win_data_c;
                grant_id_d   = pick_c;
            end
`else
            reg_write_d  = 1'b1;
            write_reg_d  = win_addr_c;
            write_data_d = win_data_c;
            grant_id_d   = pick_c;
`endif
        end
    end

    // Output stage registers; reset drops any in-flight write immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            grant_id_q   <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign wb.RegWrite  = reg_write_q;
    assign wb.WriteReg  = write_reg_q;
    assign wb.WriteData = write_data_q;
    assign wb.grant_id  = grant_id_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (NREQ=3): a table of round-robin
// vectors plus hand-written hold / conflict / register-0 / mid-reset sequences.
// Expected writes are pushed to a scoreboard when a grant is expected and
// popped when RegWrite is seen.
module tb_wb_port_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

`ifdef WB_R0_DISCARD_EN
    localparam bit DISCARD = 1'b1;
`else
    localparam bit DISCARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) wb ();

    wb_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    typedef struct {
        logic       hold;
        logic [2:0] valid;
        logic [2:0] exp_ready;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    id;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] ra[NREQ];
    logic [DW-1:0] rd[NREQ];
    logic [AW-1:0] last_reg;
    logic [DW-1:0] last_data;
    logic [1:0]    last_id;
    vec_t          rr_tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < NREQ; i++) begin
            wb.req_addr[i*AW +: AW] = ra[i];
            wb.req_data[i*DW +: DW] = rd[i];
        end
    endtask

    // One clock cycle: drive inputs, check the combinational grant, then check
    // the registered write port after the edge against the scoreboard.
    task automatic step(input logic hold, input logic [2:0] valid,
                        input logic [2:0] exp_ready, input string tag);
        int   w;
        bit   wr;
        exp_t e;
        wb.wb_hold   = hold;
        wb.req_valid = valid;
        drive_bus();
        #1;
        check({tag, " req_ready"}, 64'(wb.req_ready), 64'(exp_ready));
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (exp_ready[i]) w = i;
        end
        wr = 1'b0;
        if (w >= 0) begin
            wr = !(DISCARD && (ra[w] == '0));
            if (wr) begin
                e.addr = ra[w];
                e.data = rd[w];
                e.id   = 2'(w);
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check({tag, " RegWrite"}, 64'(wb.RegWrite), 64'(wr));
        if (wb.RegWrite === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s scoreboard: RegWrite=1 but no write expected", tag);
            end else begin
                e = sb_q.pop_front();
                check({tag, " WriteReg"},  64'(wb.WriteReg),  64'(e.addr));
                check({tag, " WriteData"}, 64'(wb.WriteData), 64'(e.data));
                check({tag, " grant_id"},  64'(wb.grant_id),  64'(e.id));
                last_reg  = e.addr;
                last_data = e.data;
                last_id   = e.id;
            end
        end else begin
            check({tag, " WriteReg hold"},  64'(wb.WriteReg),  64'(last_reg));
            check({tag, " WriteData hold"}, 64'(wb.WriteData), 64'(last_data));
            check({tag, " grant_id hold"},  64'(wb.grant_id),  64'(last_id));
        end
        $display("cycle %-8s hold=%0b valid=%b ready=%b RegWrite=%0b WriteReg=%0d WriteData=0x%0h grant_id=%0d",
                 tag, hold, valid, wb.req_ready, wb.RegWrite, wb.WriteReg, wb.WriteData, wb.grant_id);
    endtask

    // Requester obligations: a waiting request keeps valid, addr and data stable.
    logic [2:0]         pv;
    logic [2:0]         pr;
    logic [NREQ*AW-1:0] pa;
    logic [NREQ*DW-1:0] pd;
    logic               prst = 1'b0;

    always @(negedge clk) begin
        if (rst === 1'b1 && prst === 1'b1) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pv[i] && !pr[i]) begin
                    n_checks++;
                    if (!wb.req_valid[i] || wb.req_addr[i*AW +: AW] !== pa[i*AW +: AW]
                        || wb.req_data[i*DW +: DW] !== pd[i*DW +: DW]) begin
                        n_fail++;
                        $display("FAIL protocol req%0d: valid/addr/data not held while waiting", i);
                    end
                end
            end
        end
        pv   = wb.req_valid;
        pr   = wb.req_ready;
        pa   = wb.req_addr;
        pd   = wb.req_data;
        prst = rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rr_tbl[0] = '{1'b0, 3'b111, 3'b001};
        rr_tbl[1] = '{1'b0, 3'b111, 3'b010};
        rr_tbl[2] = '{1'b0, 3'b111, 3'b100};
        rr_tbl[3] = '{1'b0, 3'b111, 3'b001};
        rr_tbl[4] = '{1'b0, 3'b111, 3'b010};
        rr_tbl[5] = '{1'b0, 3'b111, 3'b100};
        rr_tbl[6] = '{1'b0, 3'b011, 3'b001};
        rr_tbl[7] = '{1'b0, 3'b010, 3'b010};
        rr_tbl[8] = '{1'b0, 3'b000, 3'b000};

        last_reg  = '0;
        last_data = '0;
        last_id   = '0;

        // Reset with every requester valid.
        rst = 1'b0;
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3;
        rd[0] = 32'hA; rd[1] = 32'hB; rd[2] = 32'hC;
        wb.wb_hold   = 1'b0;
        wb.req_valid = 3'b111;
        drive_bus();
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 64'(wb.req_ready), 64'(0));
        check("reset RegWrite",  64'(wb.RegWrite),  64'(0));
        check("reset WriteReg",  64'(wb.WriteReg),  64'(0));
        check("reset WriteData", 64'(wb.WriteData), 64'(0));
        check("reset grant_id",  64'(wb.grant_id),  64'(0));
        rst = 1'b1;

        // Round-robin from reset, including wrap-around from requester 2 to 0.
        for (int i = 0; i < 9; i++) begin
            step(rr_tbl[i].hold, rr_tbl[i].valid, rr_tbl[i].exp_ready, $sformatf("rr%0d", i));
        end

        // Same-register conflict with ptr=2: requester 2 first, requester 0 last.
        ra[0] = 5'd5; rd[0] = 32'h11;
        ra[2] = 5'd5; rd[2] = 32'h22;
        step(1'b0, 3'b101, 3'b100, "conf0");
        step(1'b0, 3'b001, 3'b001, "conf1");
        check("conflict final WriteReg",  64'(wb.WriteReg),  64'(5));
        check("conflict final WriteData", 64'(wb.WriteData), 64'(32'h11));
        step(1'b0, 3'b000, 3'b000, "idle0");

        // Hold blocks requester 1 for three cycles.
        ra[1] = 5'd7; rd[1] = 32'h12345678;
        step(1'b1, 3'b010, 3'b000, "hold0");
        step(1'b1, 3'b010, 3'b000, "hold1");
        step(1'b1, 3'b010, 3'b000, "hold2");
        step(1'b0, 3'b010, 3'b010, "hold3");
        check("hold WriteReg",  64'(wb.WriteReg),  64'(7));
        check("hold WriteData", 64'(wb.WriteData), 64'(32'h12345678));
        step(1'b0, 3'b000, 3'b000, "idle1");

        // Register 0 write from requester 0.
        ra[0] = 5'd0; rd[0] = 32'hFFFF;
        step(1'b0, 3'b001, 3'b001, "r0");
        step(1'b0, 3'b000, 3'b000, "idle2");

        // Reset asserted between edges while RegWrite is high.
        ra[1] = 5'd9; rd[1] = 32'h99;
        step(1'b0, 3'b010, 3'b010, "mrst");
        wb.req_valid = 3'b000;
        #3;
        rst = 1'b0;
        #1;
        check("mid-reset RegWrite",  64'(wb.RegWrite),  64'(0));
        check("mid-reset WriteReg",  64'(wb.WriteReg),  64'(0));
        check("mid-reset WriteData", 64'(wb.WriteData), 64'(0));
        check("mid-reset grant_id",  64'(wb.grant_id),  64'(0));
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3;
        wb.req_valid = 3'b111;
        drive_bus();
        #1;
        check("mid-reset req_ready", 64'(wb.req_ready), 64'(0));
        sb_q.delete();
        last_reg  = '0;
        last_data = '0;
        last_id   = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        // ptr restarts at 0 after release.
        step(1'b0, 3'b111, 3'b001, "post0");
        step(1'b0, 3'b110, 3'b010, "post1");
        step(1'b0, 3'b100, 3'b100, "post2");
        step(1'b0, 3'b000, 3'b000, "post3");

        check("scoreboard empty", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
